// File: rtl/sr_latch_ctrl.sv
// rtl/sr_latch_ctrl.sv - round-robin pulse controller driving one shared NAND SR latch
module sr_latch_ctrl #(
  parameter int NREQ    = 4,
  parameter int PULSE_W = 3,
  parameter int GAP_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] set_req,
  input  logic [NREQ-1:0] clr_req,
  input  logic            err_clr,
  input  logic            q_fb,
  output logic            s_n,
  output logic            r_n,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            state_exp,
  output logic            err
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX  = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  sel;
  logic              found;
  logic [NREQ-1:0]   pend;

  assign pend = set_req | clr_req;

  // First pending requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int o = 0; o < NREQ; o++) begin
      if (!found && pend[(int'(ptr) + o) % NREQ]) begin
        found = 1'b1;
        sel   = PTR_W'((int'(ptr) + o) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      s_n       <= 1'b1;
      r_n       <= 1'b1;
      grant     <= '0;
      busy      <= 1'b0;
      state_exp <= 1'b0;
      err       <= 1'b0;
    end else begin
      grant <= '0;
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state      <= PULSE;
            cnt        <= '0;
            busy       <= 1'b1;
            grant[sel] <= 1'b1;
            ptr        <= (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
            // Set wins when a requester asks for both; only one input ever goes low.
            state_exp  <= set_req[sel];
            s_n        <= !set_req[sel];
            r_n        <= set_req[sel];
          end
        end
        PULSE: begin
          if (cnt == CNT_W'(PULSE_W - 1)) begin
            state <= GAP;
            cnt   <= '0;
            s_n   <= 1'b1;
            r_n   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_W - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            // A fresh mismatch overrides a simultaneous clear.
            if (q_fb != state_exp) err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          s_n   <= 1'b1;
          r_n   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb/tb_sr_latch_ctrl.sv - directed self-checking bench for sr_latch_ctrl
module tb_sr_latch_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] set_req;
  logic [3:0] clr_req;
  logic       err_clr;
  logic       q_fb;
  logic       s_n;
  logic       r_n;
  logic [3:0] grant;
  logic       busy;
  logic       state_exp;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic q_lat    = 1'b0;
  logic stuck    = 1'b0;
  logic both_low = 1'b0;

  sr_latch_ctrl #(.NREQ(4), .PULSE_W(3), .GAP_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_req   (set_req),
    .clr_req   (clr_req),
    .err_clr   (err_clr),
    .q_fb      (q_fb),
    .s_n       (s_n),
    .r_n       (r_n),
    .grant     (grant),
    .busy      (busy),
    .state_exp (state_exp),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural NAND latch; stuck forces the feedback low.
  always @(negedge s_n) q_lat = 1'b1;
  always @(negedge r_n) q_lat = 1'b0;
  assign q_fb = stuck ? 1'b0 : q_lat;

  always @(negedge clk) if (!s_n && !r_n) both_low = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b1;
    set_req = '0;
    clr_req = '0;
    err_clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_s_n", s_n, 1);
    chk("rst_r_n", r_n, 1);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state_exp", state_exp, 0);
    chk("rst_err", err, 0);
    tick();
    rst_n = 1'b1;

    // Contention: set from 0 and clear from 2 at once.
    set_req = 4'b0001;
    clr_req = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("cont_grant", grant, (c == 1) ? 4'b0001 : (c == 7) ? 4'b0100 : 4'b0000);
      chk("cont_s_n", s_n, !(c >= 1 && c <= 3));
      chk("cont_r_n", r_n, !(c >= 7 && c <= 9));
      chk("cont_busy", busy, (c >= 1 && c <= 5) || (c >= 7 && c <= 11));
      if (c == 1) set_req = '0;
      if (c == 7) clr_req = '0;
    end
    chk("cont_state_exp", state_exp, 0);

    // Single set from requester 1.
    do_reset();
    set_req = 4'b0010;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("set_grant", grant, (c == 1) ? 4'b0010 : 4'b0000);
      chk("set_s_n", s_n, c > 3);
      chk("set_r_n", r_n, 1);
      chk("set_busy", busy, c <= 5);
      chk("set_state_exp", state_exp, 1);
      chk("set_err", err, 0);
      if (c == 1) set_req = '0;
    end

    // Fairness: all four hold set requests.
    do_reset();
    set_req = 4'b1111;
    for (int c = 1; c <= 25; c++) begin
      tick();
      case (c)
        1:       chk("rr_grant", grant, 4'b0001);
        7:       chk("rr_grant", grant, 4'b0010);
        13:      chk("rr_grant", grant, 4'b0100);
        19:      chk("rr_grant", grant, 4'b1000);
        25:      chk("rr_grant", grant, 4'b0001);
        default: chk("rr_grant_idle", grant, 4'b0000);
      endcase
    end
    set_req = '0;
    repeat (6) tick();

    // Feedback mismatch, sticky err, clear, and mismatch beating a clear.
    do_reset();
    stuck   = 1'b1;
    set_req = 4'b0001;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c == 1) set_req = '0;
      if (c == 5) chk("mm_err_pre", err, 0);
      if (c == 6) begin
        chk("mm_err_set", err, 1);
        stuck   = 1'b0;
        clr_req = 4'b0010;
      end
      if (c == 7) begin
        chk("mm_grant2", grant, 4'b0010);
        clr_req = '0;
      end
      if (c == 12) begin
        chk("mm_err_hold", err, 1);
        err_clr = 1'b1;
      end
      if (c == 13) begin
        chk("mm_err_clr", err, 0);
        err_clr = 1'b0;
        stuck   = 1'b1;
        set_req = 4'b0001;
      end
      if (c == 14) begin
        chk("mm_grant3", grant, 4'b0001);
        set_req = '0;
      end
      if (c == 18) err_clr = 1'b1;
      if (c == 19) begin
        chk("mm_err_wins", err, 1);
        err_clr = 1'b0;
      end
    end
    stuck = 1'b0;

    // Reset during a set pulse.
    do_reset();
    set_req = 4'b0100;
    tick();
    chk("mid_grant", grant, 4'b0100);
    set_req = '0;
    tick();
    chk("mid_s_n_low", s_n, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_s_n_rel", s_n, 1);
    chk("mid_busy", busy, 0);
    chk("mid_state_exp", state_exp, 0);
    #1;
    rst_n   = 1'b1;
    set_req = 4'b1010;
    tick();
    chk("mid_regrant", grant, 4'b0010);
    chk("mid_regrant_s_n", s_n, 0);
    set_req = 4'b1000;
    tick();
    set_req = '0;
    repeat (10) tick();

    chk("never_both_low", both_low, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one NAND SR latch.
REQ-002 SHALL have parameter PULSE_W, default 3: cycles an active-low drive pulse is held; legal range >= 1.
REQ-003 SHALL have parameter GAP_W, default 2: idle guard cycles after each pulse, with both latch inputs high; legal range >= 1.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port set_req  input  NREQ  per-requester level request to drive latch q to 1.
REQ-007 SHALL have port clr_req  input  NREQ  per-requester level request to drive latch q to 0.
REQ-008 SHALL have port err_clr  input  1  synchronous clear of err.
REQ-009 SHALL have port q_fb  input  1  latch q output fed back.
REQ-010 SHALL have port s_n  output  1  registered active-low latch set input.
REQ-011 SHALL have port r_n  output  1  registered active-low latch reset input.
REQ-012 SHALL have port grant  output  NREQ  one-hot; one-cycle acknowledge of the served requester.
REQ-013 SHALL have port busy  output  1  high while in PULSE or GAP.
REQ-014 SHALL have port state_exp  output  1  expected latch q after the last command.
REQ-015 SHALL have port err  output  1  sticky feedback mismatch flag.

Function
REQ-016 SHALL implement FSM states IDLE, PULSE and GAP; all outputs are registered.
REQ-017 SHALL sample requests only in IDLE; a requester is pending when set_req[i] or clr_req[i] is high.
REQ-018 SHALL arbitrate round-robin.
  - Search starts at pointer ptr.
  - After a grant, ptr = granted index + 1, modulo NREQ.
REQ-019 SHALL give set priority when one requester asserts both set_req[i] and clr_req[i].
REQ-020 SHALL, when a request is pending in IDLE at cycle k, enter PULSE at k+1, with grant[i] high for cycle k+1 only.
REQ-021 SHALL hold s_n (set) or r_n (clear) low for cycles k+1 .. k+PULSE_W, then drive it high again.
REQ-022 SHALL hold GAP for cycles k+PULSE_W+1 .. k+PULSE_W+GAP_W, and return to IDLE at k+PULSE_W+GAP_W+1.
REQ-023 SHALL accept a new request in the first IDLE cycle; back-to-back service period = 1+PULSE_W+GAP_W cycles (the first IDLE cycle counts as cycle k of the next command).
REQ-024 SHALL never drive s_n and r_n low in the same cycle (forbidden latch input), under any stimulus.
REQ-025 SHALL update state_exp to the commanded value in the first PULSE cycle.
REQ-026 SHALL execute a command whose value equals state_exp normally, with no short-circuit.
REQ-027 SHALL compare q_fb with state_exp in the last GAP cycle; on mismatch, err is set the next cycle.
REQ-028 SHALL keep err set until err_clr is sampled high.
  - If err_clr and a new mismatch fall in the same cycle, the mismatch wins.
REQ-029 SHALL ignore request changes during PULSE/GAP; requesters hold level until granted.
REQ-030 SHALL set busy = 1 exactly in PULSE and GAP cycles.

Reset
REQ-031 SHALL, on rst_n low, immediately and asynchronously force:
  - state IDLE; s_n = 1; r_n = 1; grant = 0; busy = 0;
  - state_exp = 0; err = 0; ptr = 0.
REQ-032 SHALL, on reset mid-PULSE, release the active latch input high at once and abandon the command with no error check.
REQ-033 SHALL sample requests from the first rising clk edge after rst_n deasserts.

Verification (NREQ=4, PULSE_W=3, GAP_W=2)
REQ-034 SHALL cover reset: rst_n low -> s_n=1, r_n=1, grant=0000, busy=0, state_exp=0, err=0.
REQ-035 SHALL cover single set: set_req=0010 at cycle 0, q_fb follows -> grant=0010 at cycle 1, s_n low cycles 1-3, busy cycles 1-5, state_exp=1, err=0, IDLE at cycle 6.
REQ-036 SHALL cover contention: set_req[0] and clr_req[2] high together -> grant 0001 at cycle 1 (s_n pulse), then grant 0100 at cycle 7 (r_n pulse); s_n and r_n never both low.
REQ-037 SHALL cover round-robin fairness: all four requesters hold set_req -> grants in order 0001, 0010, 0100, 1000, 0001, spaced 6 cycles apart.
REQ-038 SHALL cover feedback mismatch: q_fb stuck 0 during a set -> err=1 at cycle 6; err stays 1 through later commands until err_clr, then 0.
REQ-039 SHALL cover reset mid-pulse: rst_n low at cycle 2 of a set -> s_n=1 and busy=0 without waiting for clk; after release, the next request is granted normally from ptr=0.
